seq_addsub: RTL
===============

Name: seq_addsub

Overview:
- Parametrised, digit-serial adder/subtractor; next generation of the team's 4-bit ripple adder (a, b, cin → s, co).
- Processes WIDTH-bit operands DIGIT bits per clock, adds a subtract mode and a signed-overflow flag, and uses a start/busy/done handshake.
- Serves as the shared arithmetic unit for multi-cycle datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT compute cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- mode  in  1  0 = add (a+b+cin); 1 = subtract (a−b−cin).
- a  in  WIDTH  operand A, captured on the accepting edge.
- b  in  WIDTH  operand B, captured on the accepting edge.
- cin  in  1  carry-in (add) or borrow-in (subtract), captured with the operands.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse; result valid.
- s  out  WIDTH  result, held until the next accepted start.
- co  out  1  carry-out. In subtract mode, 1 = no borrow, 0 = borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. busy=0, done=0, s=0, co=0, ovf=0. Internal operand and carry registers are cleared.
- Reset mid-operation aborts the operation; no done pulse follows. Reset has priority over start.
- States: IDLE, RUN, DONE.
- IDLE/DONE → RUN when start=1. On that accepting edge E0:
  - load A=a.
  - load B=mode ? ~b : b.
  - load carry=mode ? ~cin : cin.
  - clear the digit counter.
- start while in RUN is ignored; operands are not re-captured.
- RUN, edges E1..EN:
  - each edge adds digit k of A and B plus carry, writes the DIGIT-bit sum into s[k*DIGIT +: DIGIT], and registers the digit carry-out.
  - the digit counter runs 0..N−1; at counter N−1 the state moves to DONE.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. start during DONE is accepted as from IDLE (back-to-back, no bubble).
- busy=1 exactly while state=RUN. done=1 exactly while state=DONE. Latency is start edge to done high = N cycles.
- s bits not yet computed during RUN are don't-care. Bench samples s, co and ovf only when done=1 or afterwards until the next acceptance.
- co = carry out of bit WIDTH−1.
- ovf = (A[MSB]==B[MSB]) && (s[MSB]!=A[MSB]), with B the effective (possibly inverted) operand. Registered on edge EN.
- s/co/ovf keep their values through IDLE. They are overwritten only by a new operation or by reset.
- WIDTH=DIGIT (N=1) is legal: one RUN cycle.

Decomposition:
- Package seq_addsub_pkg:
  - state typedef {IDLE, RUN, DONE}.
  - constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- Sub-module digit_add: combinational DIGIT-wide adder (x, y, ci → sum, co), parametrised by DIGIT. Instantiated once and shared across cycles.
- Counter width is $clog2(N) with a minimum of 1 bit.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Hold rst=1 for 2 cycles, then drop it → busy=0, done=0, s=0x0000, co=0, ovf=0. No done pulse without start.
- Add, a=0xFFFF, b=0x0001, cin=0 → busy for 4 cycles, then done for 1 cycle, with s=0x0000, co=1, ovf=0. Next, a=0x7FFF, b=0x0001 → s=0x8000, co=0, ovf=1.
- Subtract, a=0x0005, b=0x000B, cin=0 → s=0xFFFA, co=0, ovf=0. Next, a=0x8000, b=0x0001, cin=0 → s=0x7FFF, co=1, ovf=1.
- Pulse start with a=0x1234, b=0x0001 during RUN of an add of a=0x0010, b=0x0020 → ignored, s=0x0030. Then start asserted during done with a=0x0001, b=0x0002 → accepted, result s=0x0003 exactly 4 cycles later.
- Assert rst on the 2nd RUN cycle → next cycle busy=0, s=0; no done within 10 cycles. A following add of 0x0003+0x0004 → s=0x0007.
- Parameter sweep WIDTH=4, DIGIT=1: add, a=4'b1101, b=4'b0011, cin=1 → done after 4 cycles, s=4'b0001, co=1, ovf=0. Repeat at WIDTH=8, DIGIT=8 (1-cycle latency) against a random reference model, 1000 vectors, both modes.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Imported by the top and any helpers that need the state encoding.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_digit_add.sv
// Combinational DIGIT-wide adder slice.
// One instance is time-shared across all digits of an operation.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
);

  assign {co, sum} = {1'b0, x}
                   + {1'b0, y}
                   + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor, DIGIT bits per clock.
// start/busy/done handshake; results held until the next accept.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic             dco;

  digit_add #(
    .DIGIT(DIGIT)
  ) u_add (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (c_q),
    .sum(dsum),
    .co (dco)
  );

  // Operands shift right so the active digit is always at bit 0;
  // on the last digit bit DIGIT-1 is the operand sign bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dco;
        cnt_d = cnt_q + 1'b1;
        s_d[int'(cnt_q)*DIGIT +: DIGIT] = dsum;
        if (cnt_q == LAST) begin
          state_d = DONE;
          co_d    = dco;
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1])
                 && (dsum[DIGIT-1] != a_q[DIGIT-1]);
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = (mode == MODE_SUB) ? ~b : b;
          c_d     = (mode == MODE_SUB) ? ~cin : cin;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule
